// File: rtl/multi_gate_pipe_if.sv
// Stream bundle for multi_gate_pipe: operand beats in, folded results out.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the sender keeps valid and its payload stable until that edge, and ready may depend on valid.
interface multi_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2,
  parameter int CNTW  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NIN*WIDTH-1:0]  in_data;
  logic [2:0]            in_op;
  logic                  in_acc;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CNTW-1:0]       out_beats;
  logic                  out_err;

  modport master (
    output in_valid, in_data, in_op, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_err
  );

  modport slave (
    input  in_valid, in_data, in_op, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_err
  );
endinterface

// File: rtl/multi_gate_pipe.sv
// Registered N-operand bitwise gate unit with multi-beat accumulate mode.
// One output register; inversion for NOR/NAND/XNOR is applied once to the folded packet.
module multi_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2,
  parameter int CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_gate_pipe_if.slave    bus,
  output logic                dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        eff_op;
  logic [1:0]        kind;
  logic              accept, done, done_err;
  logic [WIDTH-1:0]  beat_red, merged, result;
  logic [CNTW-1:0]   done_beats;

  // 0 = OR family (including reserved 6/7), 1 = AND family, 2 = XOR family
  function automatic logic [1:0] base_kind(input logic [2:0] op);
    case (op)
      3'd1, 3'd4: return 2'd1;
      3'd2, 3'd5: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] combine(input logic [1:0] k,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (k)
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] reduce(input logic [1:0] k,
                                              input logic [NIN*WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d[WIDTH-1:0];
    for (int i = 1; i < NIN; i++) r = combine(k, r, d[i*WIDTH +: WIDTH]);
    return r;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == {CNTW{1'b1}}) ? c : c + CNTW'(1);
  endfunction

  assign bus.in_ready = rst_n & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign dbg_state    = state_q;

  // The first beat of a packet uses the live op; later beats use the latched one.
  assign eff_op   = (state_q == IDLE) ? bus.in_op : op_q;
  assign kind     = base_kind(eff_op);
  assign beat_red = reduce(kind, bus.in_data);
  assign merged   = (state_q == IDLE) ? beat_red : combine(kind, acc_q, beat_red);
  assign result   = (eff_op == 3'd3 || eff_op == 3'd4 || eff_op == 3'd5) ? ~merged : merged;
  assign done_err = eff_op[2] & eff_op[1];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    done       = 1'b0;
    done_beats = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.in_acc || bus.in_last) begin
            done       = 1'b1;
            done_beats = CNTW'(1);
          end else begin
            state_d = ACC;
            acc_d   = merged;
            cnt_d   = CNTW'(1);
            op_d    = bus.in_op;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (bus.in_last) begin
            done       = 1'b1;
            done_beats = sat_inc(cnt_q);
            state_d    = IDLE;
          end else begin
            acc_d = merged;
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      op_q          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_beats <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      // A completing packet wins over a consume in the same cycle.
      if (done) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= result;
        bus.out_beats <= done_beats;
        bus.out_err   <= done_err;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_gate_pipe.sv
// Directed bench for multi_gate_pipe (WIDTH=8, NIN=2, CNTW=8) with hand-computed results.
module tb_multi_gate_pipe;
  localparam int WIDTH = 8;
  localparam int NIN   = 2;
  localparam int CNTW  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;
  always #5 clk = ~clk;

  multi_gate_pipe_if #(.WIDTH(WIDTH), .NIN(NIN), .CNTW(CNTW)) bus ();

  multi_gate_pipe #(.WIDTH(WIDTH), .NIN(NIN), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d0,
                       input logic acc, input logic last);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = {d1, d0};
    bus.in_acc   = acc;
    bus.in_last  = last;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_acc   = 1'b0;
  endtask

  // scoreboard: compare one result against the oldest expected data
  task automatic chk_out(input string tag, input logic [CNTW-1:0] beats, input logic err);
    logic [WIDTH-1:0] e;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 64'(bus.out_data), 64'(e));
    end
    chk({tag, "_beats"}, 64'(bus.out_beats), 64'(beats));
    chk({tag, "_err"},   64'(bus.out_err),   64'(err));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    idle_in();
    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_valid",    64'(bus.out_valid), 64'd0);
    chk("rst_data",     64'(bus.out_data), 64'd0);
    chk("rst_beats",    64'(bus.out_beats), 64'd0);
    chk("rst_err",      64'(bus.out_err), 64'd0);
    chk("rst_state",    64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // one-beat OR
    drive(3'd0, 8'hF0, 8'h0F, 1'b0, 1'b0);
    #1;
    chk("or_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(8'hFF);
    step();
    chk_out("or1", 8'd1, 1'b0);

    // back-to-back NAND then NOR, out_valid held high throughout
    drive(3'd4, 8'h0F, 8'hFF, 1'b0, 1'b0);
    exp_q.push_back(8'hF0);
    step();
    chk_out("nand1", 8'd1, 1'b0);
    drive(3'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    exp_q.push_back(8'hFF);
    step();
    chk_out("nor1", 8'd1, 1'b0);
    idle_in();
    step();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // XOR accumulate, op latched from first beat
    drive(3'd2, 8'h02, 8'h01, 1'b1, 1'b0);
    step();
    chk("xacc_b1_valid", 64'(bus.out_valid), 64'd0);
    chk("xacc_b1_state", 64'(dbg_state), 64'd1);
    drive(3'd0, 8'h00, 8'h04, 1'b1, 1'b0);
    step();
    chk("xacc_b2_valid", 64'(bus.out_valid), 64'd0);
    drive(3'd0, 8'h00, 8'h80, 1'b1, 1'b1);
    exp_q.push_back(8'h87);
    step();
    chk_out("xacc", 8'd3, 1'b0);
    chk("xacc_state", 64'(dbg_state), 64'd0);

    // backpressure: result held, presented beat refused
    bus.out_ready = 1'b0;
    drive(3'd0, 8'h55, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_data",     64'(bus.out_data), 64'h87);
      chk("bp_valid",    64'(bus.out_valid), 64'd1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(8'h55);
    step();
    chk_out("bp_new", 8'd1, 1'b0);
    idle_in();
    step();

    // reserved op behaves as OR and flags the packet
    drive(3'd7, 8'h01, 8'h10, 1'b0, 1'b0);
    exp_q.push_back(8'h11);
    step();
    chk_out("rsv7", 8'd1, 1'b1);
    drive(3'd0, 8'h02, 8'h01, 1'b0, 1'b0);
    exp_q.push_back(8'h03);
    step();
    chk_out("or_after_rsv", 8'd1, 1'b0);

    // XNOR one beat: A5 inverted
    drive(3'd5, 8'h0F, 8'hAA, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    step();
    chk_out("xnor1", 8'd1, 1'b0);
    idle_in();
    step();

    // NAND accumulate: AND of F0 and 3C is 30, inverted once at the end
    drive(3'd4, 8'hF0, 8'hFF, 1'b1, 1'b0);
    step();
    drive(3'd1, 8'hFF, 8'h3C, 1'b1, 1'b1);
    exp_q.push_back(8'hCF);
    step();
    chk_out("nacc", 8'd2, 1'b0);
    idle_in();
    step();

    // reset in the middle of a packet
    drive(3'd0, 8'h12, 8'h34, 1'b1, 1'b0);
    step();
    step();
    chk("mid_state", 64'(dbg_state), 64'd1);
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data",  64'(bus.out_data), 64'd0);
    chk("mid_rst_beats", 64'(bus.out_beats), 64'd0);
    chk("mid_rst_err",   64'(bus.out_err), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    drive(3'd1, 8'h3C, 8'hF0, 1'b0, 1'b0);
    exp_q.push_back(8'h30);
    step();
    chk_out("and_post_rst", 8'd1, 1'b0);
    idle_in();
    step();

    // 300-beat OR packet: beat counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      drive(3'd0, 8'(i), 8'h00, 1'b1, (i == 300));
      if (i == 300) exp_q.push_back(8'hFF);
      step();
      if (i == 299) chk("sat_no_early_valid", 64'(bus.out_valid), 64'd0);
    end
    chk_out("sat", 8'd255, 1'b0);
    idle_in();
    step();
    chk("final_drain", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
